// File: rtl/fifo_stim_gen.sv
// Stimulus generator for a FIFO under test: INIT reset pulse, optional directed
// fill/drain prologue (FIFO_STIM_GEN_DIRECTED_EN), then LFSR-driven random vectors.
module fifo_stim_gen #(
  parameter int          FIFO_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_TXN    = 1000,
  parameter logic [31:0] SEED       = 32'hACE1_0001,
  parameter int          WR_THR     = 90,
  parameter int          RD_THR     = 38,
  parameter int          RST_THR    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  fifo_rst_n,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  drive_done,
  output logic                  test_finished,
  output logic [31:0]           txn_count,
  output logic [2:0]            o_dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_DIR_FILL  = 3'd2;
  localparam logic [2:0] S_DIR_DRAIN = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  // What the output registers load on the coming edge.
  localparam logic [2:0] K_HOLD  = 3'd0;
  localparam logic [2:0] K_INIT  = 3'd1;
  localparam logic [2:0] K_FILL  = 3'd2;
  localparam logic [2:0] K_DRAIN = 3'd3;
  localparam logic [2:0] K_RAND  = 3'd4;
  localparam logic [2:0] K_DONE  = 3'd5;

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] NUM_TXN_U = NUM_TXN;
  localparam logic [31:0] DEPTH_U   = FIFO_DEPTH;
  localparam logic [31:0] WR_THR_U  = WR_THR;
  localparam logic [31:0] RD_THR_U  = RD_THR;
  localparam logic [31:0] RST_THR_U = RST_THR;
  localparam int          DW        = (FIFO_WIDTH < 16) ? FIFO_WIDTH : 16;
  localparam int          IW        = (FIFO_WIDTH < 32) ? FIFO_WIDTH : 32;

  logic [2:0]            r_state;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_idx;
  logic                  r_init_cnt;

  logic [2:0]            w_next_state;
  logic [2:0]            w_kind;
  logic [31:0]           w_idx_next;
  logic                  w_init_cnt_next;
  logic [2:0]            w_run_state;
  logic [2:0]            w_run_kind;
  logic                  w_issue;
  logic [31:0]           w_lfsr_next;
  logic [FIFO_WIDTH-1:0] w_rand_data;
  logic [FIFO_WIDTH-1:0] w_fill_data;
  logic                  w_rand_wr;
  logic                  w_rand_rd;
  logic                  w_rand_frst;

  assign o_dbg_state = r_state;

  always_comb begin
    w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'd0);
    w_rand_data = '0;
    w_rand_data[DW-1:0] = r_lfsr[DW-1:0];
    w_fill_data = '0;
    w_fill_data[IW-1:0] = r_idx[IW-1:0];
    w_rand_wr   = ({25'd0, r_lfsr[22:16]} < WR_THR_U);
    w_rand_rd   = ({25'd0, r_lfsr[29:23]} < RD_THR_U);
    w_rand_frst = ({25'd0, r_lfsr[31:30], r_lfsr[4:0]} >= RST_THR_U);
  end

  always_comb begin
    w_next_state    = r_state;
    w_kind          = K_HOLD;
    w_idx_next      = r_idx;
    w_init_cnt_next = r_init_cnt;
    // With NUM_TXN=0 the random phase is skipped entirely.
    if (NUM_TXN_U == 32'd0) begin
      w_run_state = S_DONE;
      w_run_kind  = K_DONE;
    end else begin
      w_run_state = S_RUN;
      w_run_kind  = K_RAND;
    end
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state    = S_INIT;
          w_kind          = K_INIT;
          w_idx_next      = 32'd0;
          w_init_cnt_next = 1'b0;
        end
      end
      S_INIT: begin
        w_init_cnt_next = 1'b1;
        if (r_init_cnt) begin
`ifdef FIFO_STIM_GEN_DIRECTED_EN
          w_next_state = S_DIR_FILL;
          w_kind       = K_FILL;
`else
          w_next_state = w_run_state;
          w_kind       = w_run_kind;
`endif
          w_idx_next   = 32'd1;
        end
      end
      S_DIR_FILL: begin
        if (r_idx == DEPTH_U) begin
          w_next_state = S_DIR_DRAIN;
          w_kind       = K_DRAIN;
          w_idx_next   = 32'd1;
        end else begin
          w_kind     = K_FILL;
          w_idx_next = r_idx + 32'd1;
        end
      end
      S_DIR_DRAIN: begin
        // One read beyond FIFO_DEPTH deliberately provokes underflow.
        if (r_idx == DEPTH_U + 32'd1) begin
          w_next_state = w_run_state;
          w_kind       = w_run_kind;
          w_idx_next   = 32'd1;
        end else begin
          w_kind     = K_DRAIN;
          w_idx_next = r_idx + 32'd1;
        end
      end
      S_RUN: begin
        if (r_idx == NUM_TXN_U) begin
          w_next_state = S_DONE;
          w_kind       = K_DONE;
        end else begin
          w_kind     = K_RAND;
          w_idx_next = r_idx + 32'd1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    w_issue = (w_kind == K_FILL) || (w_kind == K_DRAIN) || (w_kind == K_RAND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_idx         <= 32'd0;
      r_init_cnt    <= 1'b0;
      fifo_rst_n    <= 1'b0;
      wr_en         <= 1'b0;
      rd_en         <= 1'b0;
      data_in       <= '0;
      drive_done    <= 1'b0;
      test_finished <= 1'b0;
      txn_count     <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_idx_next;
      r_init_cnt <= w_init_cnt_next;
      drive_done <= w_issue;
      if (w_issue) begin
        txn_count <= txn_count + 32'd1;
        r_lfsr    <= w_lfsr_next;
      end
      case (w_kind)
        K_INIT: begin
          fifo_rst_n    <= 1'b0;
          wr_en         <= 1'b0;
          rd_en         <= 1'b0;
          test_finished <= 1'b0;
          txn_count     <= 32'd0;
        end
        K_FILL: begin
          fifo_rst_n <= 1'b1;
          wr_en      <= 1'b1;
          rd_en      <= 1'b0;
          data_in    <= w_fill_data;
        end
        K_DRAIN: begin
          fifo_rst_n <= 1'b1;
          wr_en      <= 1'b0;
          rd_en      <= 1'b1;
        end
        K_RAND: begin
          fifo_rst_n <= w_rand_frst;
          wr_en      <= w_rand_wr;
          rd_en      <= w_rand_rd;
          data_in    <= w_rand_data;
        end
        K_DONE: begin
          fifo_rst_n    <= 1'b1;
          wr_en         <= 1'b0;
          rd_en         <= 1'b0;
          test_finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Bench for fifo_stim_gen: three instances with different seeds/thresholds/NUM_TXN,
// checked against a queue-based vector model and a few hand-computed values.
module tb_fifo_stim_gen;

  localparam int DEPTH = 8;
`ifdef FIFO_STIM_GEN_DIRECTED_EN
  localparam int PRO = 2 * DEPTH + 1;
`else
  localparam int PRO = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [2:0]  frst, wr, rd, dd, fin;
  logic [15:0] din [3];
  logic [31:0] cnt [3];
  logic [2:0]  dbg [3];

  logic [31:0] m_seed [3] = '{32'h0000_0001, 32'hACE1_0001, 32'h1234_5678};
  int          m_ntxn [3] = '{4, 10, 0};
  int          m_wr   [3] = '{90, 128, 90};
  int          m_rd   [3] = '{38, 0, 38};
  int          m_rst  [3] = '{2, 0, 2};
  logic [31:0] m_lfsr [3];
  int          issued [3];
  logic [15:0] last_data [3];
  bit          last_known [3];

  // {check_data, frst, rd, wr, data}
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  logic [19:0] exp_q2[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_stim_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .NUM_TXN(4), .SEED(32'h0000_0001),
                  .WR_THR(90), .RD_THR(38), .RST_THR(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_rst_n(frst[0]), .data_in(din[0]),
    .wr_en(wr[0]), .rd_en(rd[0]), .drive_done(dd[0]), .test_finished(fin[0]),
    .txn_count(cnt[0]), .o_dbg_state(dbg[0]));

  fifo_stim_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .NUM_TXN(10), .SEED(32'hACE1_0001),
                  .WR_THR(128), .RD_THR(0), .RST_THR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_rst_n(frst[1]), .data_in(din[1]),
    .wr_en(wr[1]), .rd_en(rd[1]), .drive_done(dd[1]), .test_finished(fin[1]),
    .txn_count(cnt[1]), .o_dbg_state(dbg[1]));

  fifo_stim_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .NUM_TXN(0), .SEED(32'h1234_5678),
                  .WR_THR(90), .RD_THR(38), .RST_THR(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_rst_n(frst[2]), .data_in(din[2]),
    .wr_en(wr[2]), .rd_en(rd[2]), .drive_done(dd[2]), .test_finished(fin[2]),
    .txn_count(cnt[2]), .o_dbg_state(dbg[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int i, input logic [19:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [19:0] v, output bit ok);
    ok = 1'b1;
    v = '0;
    case (i)
      0: if (exp_q0.size() > 0) v = exp_q0.pop_front(); else ok = 1'b0;
      1: if (exp_q1.size() > 0) v = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) v = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  // Full expected vector list for one start; the LFSR carries over between starts.
  task automatic build_run(input int i);
    logic [31:0] s;
    logic [6:0]  rf;
    s = m_lfsr[i];
`ifdef FIFO_STIM_GEN_DIRECTED_EN
    for (int k = 0; k < DEPTH; k++) begin
      push_exp(i, {1'b1, 1'b1, 1'b0, 1'b1, 16'(k)});
      s = lfsr_step(s);
    end
    for (int k = 0; k <= DEPTH; k++) begin
      push_exp(i, {1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
      s = lfsr_step(s);
    end
`endif
    for (int k = 0; k < m_ntxn[i]; k++) begin
      rf = {s[31:30], s[4:0]};
      push_exp(i, {1'b1, (int'(rf) >= m_rst[i]), (int'(s[29:23]) < m_rd[i]),
                   (int'(s[22:16]) < m_wr[i]), s[15:0]});
      s = lfsr_step(s);
    end
    m_lfsr[i] = s;
    issued[i] = 0;
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < 3; i++) begin
      m_lfsr[i] = m_seed[i];
      issued[i] = 0;
      last_data[i] = 16'd0;
      last_known[i] = 1'b1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_frst[%0d]", tag, i), 32'(frst[i]), 32'd0);
      check($sformatf("%s_wr[%0d]", tag, i), 32'(wr[i]), 32'd0);
      check($sformatf("%s_rd[%0d]", tag, i), 32'(rd[i]), 32'd0);
      check($sformatf("%s_data[%0d]", tag, i), 32'(din[i]), 32'd0);
      check($sformatf("%s_dd[%0d]", tag, i), 32'(dd[i]), 32'd0);
      check($sformatf("%s_fin[%0d]", tag, i), 32'(fin[i]), 32'd0);
      check($sformatf("%s_cnt[%0d]", tag, i), cnt[i], 32'd0);
    end
  endtask

  // Every drive_done pulse must match the next model vector and the running count.
  always @(negedge clk) begin
    logic [19:0] v;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (dd[i]) begin
        pop_exp(i, v, ok);
        if (!ok) begin
          check($sformatf("spurious_drive_done[%0d]", i), 32'd1, 32'd0);
        end else begin
          issued[i]++;
          check($sformatf("vec_wr[%0d]", i), 32'(wr[i]), 32'(v[16]));
          check($sformatf("vec_rd[%0d]", i), 32'(rd[i]), 32'(v[17]));
          check($sformatf("vec_frst[%0d]", i), 32'(frst[i]), 32'(v[18]));
          check($sformatf("vec_fin[%0d]", i), 32'(fin[i]), 32'd0);
          if (v[19]) begin
            check($sformatf("vec_data[%0d]", i), 32'(din[i]), 32'(v[15:0]));
            last_data[i] = v[15:0];
            last_known[i] = 1'b1;
          end else begin
            last_known[i] = 1'b0;
          end
          check($sformatf("vec_cnt[%0d]", i), cnt[i], 32'(issued[i]));
        end
      end
    end
  end

  task automatic do_run(input bit pin, input int abort_at);
    for (int i = 0; i < 3; i++) build_run(i);
`ifndef FIFO_STIM_GEN_DIRECTED_EN
    if (pin) begin
      // SEED=1: first vector 0x0001, then (1>>1)^taps = 0x80200003 -> 0x0003.
      check("model_a_v0", 32'(exp_q0[0][15:0]), 32'h0001);
      check("model_a_v1", 32'(exp_q0[1][15:0]), 32'h0003);
    end
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("init%0d_frst[%0d]", c, i), 32'(frst[i]), 32'd0);
        check($sformatf("init%0d_dd[%0d]", c, i), 32'(dd[i]), 32'd0);
        check($sformatf("init%0d_wr[%0d]", c, i), 32'(wr[i]), 32'd0);
        check($sformatf("init%0d_cnt[%0d]", c, i), cnt[i], 32'd0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("first_dd[%0d]", i), 32'(dd[i]), 32'((PRO + m_ntxn[i]) > 0));
      check($sformatf("first_fin[%0d]", i), 32'(fin[i]), 32'((PRO + m_ntxn[i]) == 0));
    end
`ifndef FIFO_STIM_GEN_DIRECTED_EN
    if (pin) begin
      check("lit_a0_data", 32'(din[0]), 32'h0001);
      check("lit_a0_wr", 32'(wr[0]), 32'd1);
      check("lit_a0_rd", 32'(rd[0]), 32'd1);
      check("lit_a0_frst", 32'(frst[0]), 32'd0);
      check("lit_b0_en", {29'd0, frst[1], rd[1], wr[1]}, 32'b101);
    end
`endif
    @(negedge clk);
`ifndef FIFO_STIM_GEN_DIRECTED_EN
    if (pin) begin
      check("lit_a1_data", 32'(din[0]), 32'h0003);
      check("lit_a1_frst", 32'(frst[0]), 32'd1);
      check("lit_b1_en", {29'd0, frst[1], rd[1], wr[1]}, 32'b101);
    end
`endif
    if (abort_at > 0) begin
      for (int k = 2; k < abort_at; k++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_vals("idle_after_rst");
    end else begin
      for (int k = 0; k < 300 && fin != 3'b111; k++) @(negedge clk);
      check("finish_timeout", 32'(fin), 32'b111);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("done_cnt[%0d]", i), cnt[i], 32'(PRO + m_ntxn[i]));
        check($sformatf("done_left[%0d]", i), 32'(q_size(i)), 32'd0);
        check($sformatf("done_en[%0d]", i), {29'd0, frst[i], rd[i], wr[i]}, 32'b100);
        if (last_known[i]) check($sformatf("done_data[%0d]", i), 32'(din[i]), 32'(last_data[i]));
      end
      repeat (2) @(negedge clk);
      check("done_sticky", {27'd0, fin, dd}, {27'd0, 3'b111, 3'b000});
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("idle");
    do_run(1'b1, 0);
    do_run(1'b0, 0);
    do_run(1'b0, 3);
    do_run(1'b1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
